// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell evaluated LSB first, one bit per clock,
// with a valid/ready operand port and a held result port.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             CK,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               c_msb_in;
  logic               fa_s, fa_co;
  logic               last_bit;

  assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_co    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)         state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (flush || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush discards the partial/unclaimed result; a normal handshake leaves it visible.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            sum_sh   <= '0;
            c_msb_in <= 1'b0;
          end
        end
        RUN: begin
          if (flush) begin
            sum_sh   <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
          end else begin
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= fa_co;
            if (last_bit) c_msb_in <= carry;
            else          cnt      <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (flush) begin
            sum_sh   <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;
  assign ovf  = c_msb_in ^ carry;

endmodule
